// File: rtl/uart_sys_ctrl.sv
// uart_sys_ctrl: UART command sequencer driving register-file and ALU ports and returning results to the UART transmitter
module uart_sys_ctrl #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rx_valid,
    input  logic [WIDTH-1:0]      i_rx_data,
    output logic                  o_tx_valid,
    output logic [WIDTH-1:0]      o_tx_data,
    input  logic                  i_tx_busy,
    output logic                  o_rf_wr_en,
    output logic                  o_rf_rd_en,
    output logic [ADDR_WIDTH-1:0] o_rf_addr,
    output logic [WIDTH-1:0]      o_rf_wr_data,
    input  logic [WIDTH-1:0]      i_rf_rd_data,
    input  logic                  i_rf_rd_valid,
    output logic                  o_alu_en,
    output logic [3:0]            o_alu_fun,
    input  logic [2*WIDTH-1:0]    i_alu_out,
    input  logic                  i_alu_valid,
    output logic                  o_cmd_err
);
    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_WR_ADDR    = 4'd1;
    localparam logic [3:0] S_WR_DATA    = 4'd2;
    localparam logic [3:0] S_RD_ADDR    = 4'd3;
    localparam logic [3:0] S_RD_WAIT    = 4'd4;
    localparam logic [3:0] S_OPA        = 4'd5;
    localparam logic [3:0] S_OPB        = 4'd6;
    localparam logic [3:0] S_FUN        = 4'd7;
    localparam logic [3:0] S_ALU_WAIT   = 4'd8;
    localparam logic [3:0] S_TX_LOAD    = 4'd9;
    localparam logic [3:0] S_TX_WAIT_HI = 4'd10;
    localparam logic [3:0] S_TX_WAIT_LO = 4'd11;

    localparam logic [WIDTH-1:0] CMD_WR  = WIDTH'(8'hAA);
    localparam logic [WIDTH-1:0] CMD_RD  = WIDTH'(8'hBB);
    localparam logic [WIDTH-1:0] CMD_OPS = WIDTH'(8'hCC);
    localparam logic [WIDTH-1:0] CMD_ALU = WIDTH'(8'hDD);

    logic [3:0]            state_q, state_d;
    logic [2*WIDTH-1:0]    tx_buf_q, tx_buf_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [WIDTH-1:0]      tx_data_q, tx_data_d;
    logic                  rf_wr_en_q, rf_wr_en_d;
    logic                  rf_rd_en_q, rf_rd_en_d;
    logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
    logic [WIDTH-1:0]      rf_wr_data_q, rf_wr_data_d;
    logic                  alu_en_q, alu_en_d;
    logic [3:0]            alu_fun_q, alu_fun_d;
    logic                  cmd_err_q, cmd_err_d;
    logic                  addr_bad;
    logic                  busy_state;

    assign addr_bad   = (i_rx_data >> ADDR_WIDTH) != '0;
    assign busy_state = state_q inside {S_RD_WAIT, S_ALU_WAIT, S_TX_LOAD, S_TX_WAIT_HI, S_TX_WAIT_LO};

    // Frame decode, request strobes and the byte-by-byte transmit handshake
    always_comb begin
        state_d      = state_q;
        tx_buf_d     = tx_buf_q;
        cnt_d        = cnt_q;
        tx_valid_d   = tx_valid_q;
        tx_data_d    = tx_data_q;
        rf_addr_d    = rf_addr_q;
        rf_wr_data_d = rf_wr_data_q;
        alu_fun_d    = alu_fun_q;
        rf_wr_en_d   = 1'b0;
        rf_rd_en_d   = 1'b0;
        alu_en_d     = 1'b0;
        cmd_err_d    = 1'b0;
        case (state_q)
            S_IDLE: if (i_rx_valid) begin
                state_d   = i_rx_data == CMD_WR  ? S_WR_ADDR :
                            i_rx_data == CMD_RD  ? S_RD_ADDR :
                            i_rx_data == CMD_OPS ? S_OPA     :
                            i_rx_data == CMD_ALU ? S_FUN     : S_IDLE;
                cmd_err_d = state_d == S_IDLE;
            end
            S_WR_ADDR, S_RD_ADDR: if (i_rx_valid) begin
                cmd_err_d  = addr_bad;
                rf_rd_en_d = !addr_bad && state_q == S_RD_ADDR;
                rf_addr_d  = addr_bad ? rf_addr_q : i_rx_data[ADDR_WIDTH-1:0];
                state_d    = addr_bad ? S_IDLE : state_q == S_RD_ADDR ? S_RD_WAIT : S_WR_DATA;
            end
            S_WR_DATA: if (i_rx_valid) begin
                rf_wr_en_d   = 1'b1;
                rf_wr_data_d = i_rx_data;
                state_d      = S_IDLE;
            end
            S_OPA, S_OPB: if (i_rx_valid) begin
                rf_wr_en_d   = 1'b1;
                rf_addr_d    = state_q == S_OPB ? ADDR_WIDTH'(1) : '0;
                rf_wr_data_d = i_rx_data;
                state_d      = state_q == S_OPB ? S_FUN : S_OPB;
            end
            S_FUN: if (i_rx_valid) begin
                alu_en_d  = 1'b1;
                alu_fun_d = i_rx_data[3:0];
                state_d   = S_ALU_WAIT;
            end
            S_RD_WAIT: if (i_rf_rd_valid) begin
                tx_buf_d = (2*WIDTH)'(i_rf_rd_data);
                cnt_d    = 2'd1;
                state_d  = S_TX_LOAD;
            end
            S_ALU_WAIT: if (i_alu_valid) begin
                tx_buf_d = i_alu_out;
                cnt_d    = 2'd2;
                state_d  = S_TX_LOAD;
            end
            S_TX_LOAD: if (!i_tx_busy) begin
                tx_data_d  = tx_buf_q[WIDTH-1:0];
                tx_valid_d = 1'b1;
                state_d    = S_TX_WAIT_HI;
            end
            S_TX_WAIT_HI: if (i_tx_busy) begin
                tx_valid_d = 1'b0;
                state_d    = S_TX_WAIT_LO;
            end
            S_TX_WAIT_LO: if (!i_tx_busy) begin
                cnt_d    = cnt_q - 2'd1;
                tx_buf_d = tx_buf_q >> WIDTH;
                state_d  = cnt_d != 2'd0 ? S_TX_LOAD : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (i_rx_valid && busy_state)
            cmd_err_d = 1'b1;
    end

    // State and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            tx_buf_q     <= '0;
            cnt_q        <= '0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= '0;
            rf_wr_en_q   <= 1'b0;
            rf_rd_en_q   <= 1'b0;
            rf_addr_q    <= '0;
            rf_wr_data_q <= '0;
            alu_en_q     <= 1'b0;
            alu_fun_q    <= '0;
            cmd_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_buf_q     <= tx_buf_d;
            cnt_q        <= cnt_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_rd_en_q   <= rf_rd_en_d;
            rf_addr_q    <= rf_addr_d;
            rf_wr_data_q <= rf_wr_data_d;
            alu_en_q     <= alu_en_d;
            alu_fun_q    <= alu_fun_d;
            cmd_err_q    <= cmd_err_d;
        end
    end

    assign o_tx_valid   = tx_valid_q;
    assign o_tx_data    = tx_data_q;
    assign o_rf_wr_en   = rf_wr_en_q;
    assign o_rf_rd_en   = rf_rd_en_q;
    assign o_rf_addr    = rf_addr_q;
    assign o_rf_wr_data = rf_wr_data_q;
    assign o_alu_en     = alu_en_q;
    assign o_alu_fun    = alu_fun_q;
    assign o_cmd_err    = cmd_err_q;
endmodule
